// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and the instruction memory.
// One request is accepted per req&&ready; exactly one rvalid pulse returns per
// accepted request, in order.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  // Fetch side issues requests and consumes read data.
  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  // Memory side accepts requests and returns read data.
  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, keeps at most one instruction read in
// flight, applies decode predictions and execute corrections, and drives the
// FD pipeline register. A one-entry hold buffer catches a response that returns
// while decode is stalled so nothing is lost or duplicated.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                D_stall_i,
  input  logic                D_flush_i,
  input  logic                D_predictPC_i,
  input  logic [31:0]         D_PCprediction_i,
  input  logic                E_correctPC_i,
  input  logic [31:0]         E_PCcorrection_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         FD_PC_o,
  output logic [31:0]         FD_instr_o,
  output logic                FD_nop_o
);

  localparam logic [31:0] NOP       = 32'h0000_0033;
  localparam logic [31:0] ALIGN     = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC  = RESET_ADDR & ALIGN;

  typedef enum logic [1:0] {
    S_IDLE, // nothing outstanding
    S_WAIT, // one request outstanding, data wanted
    S_DROP, // one request outstanding, data is wrong-path
    S_HOLD  // response captured in the hold buffer during a stall
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inflight_pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] fd_pc_q;
  logic [31:0] fd_instr_q;
  logic        fd_nop_q;

  logic        pred_taken;
  logic        redir;
  logic [31:0] tgt;
  logic        slot_free;
  logic        req_d;

  // Target selection and request decision for the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pred_taken = 1'b0;
    redir      = 1'b0;
    tgt        = pc_q;
    slot_free  = 1'b0;
    req_d      = 1'b0;

    // A prediction only counts for a real, non-stalled instruction in FD.
    pred_taken = D_predictPC_i && !fd_nop_q && !D_stall_i;
    redir      = E_correctPC_i || pred_taken;
    if (E_correctPC_i)   tgt = E_PCcorrection_i & ALIGN;
    else if (pred_taken) tgt = D_PCprediction_i & ALIGN;

    unique case (state_q)
      S_IDLE:         slot_free = 1'b1;
      S_WAIT, S_DROP: slot_free = imem.rvalid;
      // A correction makes the buffered word wrong-path, so it frees the slot even when stalled.
      S_HOLD:         slot_free = !D_stall_i || E_correctPC_i;
      default:        slot_free = 1'b0;
    endcase

    // Data returning into a stalled decode goes to the hold buffer instead of issuing.
    req_d = slot_free &&
            !(state_q == S_WAIT && imem.rvalid && D_stall_i && !redir);
  end

  assign imem.req   = req_d && !reset_i;
  assign imem.addr  = tgt;
  assign FD_PC_o    = fd_pc_q;
  assign FD_instr_o = fd_instr_q;
  assign FD_nop_o   = fd_nop_q;

  // Fetch FSM, PC, hold buffer and FD register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= 32'h0;
      hold_pc_q     <= 32'h0;
      hold_instr_q  <= NOP;
      fd_pc_q       <= 32'h0;
      fd_instr_q    <= NOP;
      fd_nop_q      <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
      if (req_d) begin
        if (imem.ready) begin
          state_q       <= S_WAIT;
          pc_q          <= tgt + 32'd4;
          inflight_pc_q <= tgt;
        end else begin
          // Not accepted: re-drive the same address next cycle unless redirected.
          state_q <= S_IDLE;
          pc_q    <= tgt;
        end
      end else begin
        unique case (state_q)
          S_WAIT: begin
            if (imem.rvalid) begin
              state_q      <= S_HOLD;
              hold_pc_q    <= inflight_pc_q;
              hold_instr_q <= imem.rdata;
            end else if (redir) begin
              state_q <= S_DROP;
              pc_q    <= tgt;
            end
          end
          S_DROP: begin
            if (redir) pc_q <= tgt;
          end
          default: begin
            // IDLE always issues; HOLD just waits for the stall to clear.
          end
        endcase
      end

      // FD update in priority order.
      if (E_correctPC_i || D_flush_i) begin
        fd_nop_q   <= 1'b1;
        fd_instr_q <= NOP;
      end else if (D_stall_i) begin
        fd_nop_q <= fd_nop_q;
      end else if (pred_taken) begin
        fd_nop_q   <= 1'b1;
        fd_instr_q <= NOP;
      end else if (state_q == S_HOLD) begin
        fd_pc_q    <= hold_pc_q;
        fd_instr_q <= hold_instr_q;
        fd_nop_q   <= 1'b0;
      end else if (state_q == S_WAIT && imem.rvalid) begin
        fd_pc_q    <= inflight_pc_q;
        fd_instr_q <= imem.rdata;
        fd_nop_q   <= 1'b0;
      end else begin
        fd_nop_q   <= 1'b1;
        fd_instr_q <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction-memory model with
// selectable latency returns ~addr as the instruction word.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_stall, D_flush, D_predictPC, E_correctPC;
  logic [31:0] D_PCprediction, E_PCcorrection;
  logic [31:0] FD_PC, FD_instr;
  logic        FD_nop;

  int passed = 0;
  int total  = 0;
  int mem_lat = 1;
  int cnt_100 = 0;

  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .D_stall_i        (D_stall),
    .D_flush_i        (D_flush),
    .D_predictPC_i    (D_predictPC),
    .D_PCprediction_i (D_PCprediction),
    .E_correctPC_i    (E_correctPC),
    .E_PCcorrection_i (E_PCcorrection),
    .imem             (imem),
    .FD_PC_o          (FD_PC),
    .FD_instr_o       (FD_instr),
    .FD_nop_o         (FD_nop)
  );

  always #5 clk = ~clk;

  // Memory model: one response per accepted request, mem_lat cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem.rvalid <= 1'b0;
      imem.rdata  <= 32'h0;
      pend_valid  <= 1'b0;
      pend_addr   <= 32'h0;
      pend_cnt    <= 0;
    end else begin
      imem.rvalid <= 1'b0;
      if (pend_valid) begin
        if (pend_cnt == 1) begin
          imem.rvalid <= 1'b1;
          imem.rdata  <= ~pend_addr;
          pend_valid  <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (imem.req && imem.ready) begin
        if (imem.addr == 32'h100) cnt_100 <= cnt_100 + 1;
        if (mem_lat == 1) begin
          imem.rvalid <= 1'b1;
          imem.rdata  <= ~imem.addr;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= imem.addr;
          pend_cnt   <= mem_lat - 1;
        end
      end
    end
  end

  // Assert reset for two cycles and release it on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    D_stall = 0; D_flush = 0; D_predictPC = 0; E_correctPC = 0;
    D_PCprediction = 32'h0; E_PCcorrection = 32'h0;
    imem.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    D_stall = 0; D_flush = 0; D_predictPC = 0; E_correctPC = 0;
    D_PCprediction = 32'h0; E_PCcorrection = 32'h0;
    imem.ready = 1'b1;
    @(negedge clk); #1;
    total++; if (imem.req !== 1'b0) $display("FAIL reset_req got %b want 0", imem.req); else passed++;
    total++; if (FD_nop !== 1'b1) $display("FAIL reset_nop got %b want 1", FD_nop); else passed++;
    total++; if (FD_instr !== NOP) $display("FAIL reset_instr got %h want %h", FD_instr, NOP); else passed++;
    total++; if (FD_PC !== 32'h0) $display("FAIL reset_pc got %h want 0", FD_PC); else passed++;
    @(negedge clk);
    rst = 1'b0; #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h0)
      $display("FAIL first_req got req=%b addr=%h want 1/0", imem.req, imem.addr); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      total++; if (imem.addr !== 32'(4 * i))
        $display("FAIL stream_addr[%0d] got %h want %h", i, imem.addr, 32'(4 * i)); else passed++;
      if (i >= 2) begin
        total++; if (FD_nop !== 1'b0 || FD_PC !== 32'(4 * (i - 2)) || FD_instr !== ~32'(4 * (i - 2)))
          $display("FAIL stream_fd[%0d] got nop=%b pc=%h instr=%h want 0/%h", i, FD_nop, FD_PC,
                   FD_instr, 32'(4 * (i - 2))); else passed++;
      end else begin
        total++; if (FD_nop !== 1'b1) $display("FAIL stream_bubble got %b want 1", FD_nop); else passed++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    D_stall = 1'b1; #1;
    total++; if (imem.req !== 1'b0) $display("FAIL stall_noreq got %b want 0", imem.req); else passed++;
    total++; if (FD_PC !== 32'h0 || FD_nop !== 1'b0)
      $display("FAIL stall_fd0 got pc=%h nop=%b want 0/0", FD_PC, FD_nop); else passed++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++; if (imem.req !== 1'b0 || FD_PC !== 32'h0 || FD_nop !== 1'b0)
        $display("FAIL stall_frozen[%0d] got req=%b pc=%h nop=%b want 0/0/0", k, imem.req, FD_PC, FD_nop);
      else passed++;
    end
    @(negedge clk);
    D_stall = 1'b0; #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h8)
      $display("FAIL stall_resume_req got req=%b addr=%h want 1/8", imem.req, imem.addr); else passed++;
    @(negedge clk); #1;
    total++; if (FD_PC !== 32'h4 || FD_nop !== 1'b0 || FD_instr !== ~32'h4)
      $display("FAIL stall_hold_out got pc=%h nop=%b instr=%h want 4/0", FD_PC, FD_nop, FD_instr); else passed++;
    @(negedge clk); #1;
    total++; if (FD_PC !== 32'h8 || FD_nop !== 1'b0)
      $display("FAIL stall_next got pc=%h nop=%b want 8/0", FD_PC, FD_nop); else passed++;
  endtask

  task automatic test_predict();
    do_reset();
    repeat (4) @(negedge clk);
    D_predictPC = 1'b1; D_PCprediction = 32'h100; #1;
    total++; if (FD_PC !== 32'h8 || FD_nop !== 1'b0)
      $display("FAIL pred_fd8 got pc=%h nop=%b want 8/0", FD_PC, FD_nop); else passed++;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h100)
      $display("FAIL pred_addr got req=%b addr=%h want 1/100", imem.req, imem.addr); else passed++;
    @(negedge clk);
    D_predictPC = 1'b0; #1;
    total++; if (FD_nop !== 1'b1) $display("FAIL pred_bubble got %b want 1", FD_nop); else passed++;
    @(negedge clk); #1;
    total++; if (FD_PC !== 32'h100 || FD_nop !== 1'b0 || FD_instr !== ~32'h100)
      $display("FAIL pred_target got pc=%h nop=%b instr=%h want 100/0", FD_PC, FD_nop, FD_instr); else passed++;
  endtask

  task automatic test_correct();
    int c0;
    do_reset();
    c0 = cnt_100;
    repeat (4) @(negedge clk);
    E_correctPC = 1'b1; E_PCcorrection = 32'h200;
    D_predictPC = 1'b1; D_PCprediction = 32'h100; #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h200)
      $display("FAIL corr_addr got req=%b addr=%h want 1/200", imem.req, imem.addr); else passed++;
    @(negedge clk);
    E_correctPC = 1'b0; D_predictPC = 1'b0; #1;
    total++; if (FD_nop !== 1'b1 || FD_instr !== NOP)
      $display("FAIL corr_flush got nop=%b instr=%h want 1/%h", FD_nop, FD_instr, NOP); else passed++;
    total++; if (imem.addr !== 32'h204) $display("FAIL corr_next got %h want 204", imem.addr); else passed++;
    @(negedge clk); #1;
    total++; if (FD_PC !== 32'h200 || FD_nop !== 1'b0)
      $display("FAIL corr_fd got pc=%h nop=%b want 200/0", FD_PC, FD_nop); else passed++;
    total++; if (cnt_100 !== c0) $display("FAIL corr_no_100 got %0d fetches want 0", cnt_100 - c0); else passed++;
  endtask

  task automatic test_drop();
    bit got_valid;
    mem_lat = 3;
    do_reset();
    E_correctPC = 1'b1; E_PCcorrection = 32'h10; #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h10)
      $display("FAIL drop_req10 got req=%b addr=%h want 1/10", imem.req, imem.addr); else passed++;
    @(negedge clk);
    E_PCcorrection = 32'h300; #1;
    total++; if (imem.req !== 1'b0) $display("FAIL drop_noreq got %b want 0", imem.req); else passed++;
    @(negedge clk);
    E_correctPC = 1'b0; #1;
    total++; if (imem.req !== 1'b0) $display("FAIL drop_wait got %b want 0", imem.req); else passed++;
    @(negedge clk); #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h300 || FD_nop !== 1'b1)
      $display("FAIL drop_reissue got req=%b addr=%h nop=%b want 1/300/1", imem.req, imem.addr, FD_nop);
    else passed++;
    got_valid = 1'b0;
    for (int k = 0; k < 12 && !got_valid; k++) begin
      @(negedge clk); #1;
      if (FD_nop === 1'b0) got_valid = 1'b1;
    end
    total++; if (!got_valid || FD_PC !== 32'h300 || FD_instr !== ~32'h300)
      $display("FAIL drop_first_valid got valid=%b pc=%h instr=%h want 1/300", got_valid, FD_PC, FD_instr);
    else passed++;
    mem_lat = 1;
  endtask

  task automatic test_ready();
    do_reset();
    imem.ready = 1'b0; E_correctPC = 1'b1; E_PCcorrection = 32'h20; #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h20)
      $display("FAIL rdy_req got req=%b addr=%h want 1/20", imem.req, imem.addr); else passed++;
    @(negedge clk);
    E_correctPC = 1'b0; #1;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h20 || FD_nop !== 1'b1)
      $display("FAIL rdy_held got req=%b addr=%h nop=%b want 1/20/1", imem.req, imem.addr, FD_nop); else passed++;
    @(negedge clk);
    imem.ready = 1'b1; #1;
    total++; if (imem.addr !== 32'h20 || FD_nop !== 1'b1)
      $display("FAIL rdy_stable got addr=%h nop=%b want 20/1", imem.addr, FD_nop); else passed++;
    @(negedge clk); #1;
    total++; if (imem.addr !== 32'h24) $display("FAIL rdy_next got %h want 24", imem.addr); else passed++;
    @(negedge clk); #1;
    total++; if (FD_PC !== 32'h20 || FD_nop !== 1'b0)
      $display("FAIL rdy_fd got pc=%h nop=%b want 20/0", FD_PC, FD_nop); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    E_correctPC = 1'b1; E_PCcorrection = 32'hFFFF_FFFE; #1;
    total++; if (imem.addr !== 32'hFFFF_FFFC) $display("FAIL wrap_align got %h want fffffffc", imem.addr); else passed++;
    @(negedge clk);
    E_correctPC = 1'b0; #1;
    total++; if (imem.addr !== 32'h0) $display("FAIL wrap_addr got %h want 0", imem.addr); else passed++;
    @(negedge clk); #1;
    total++; if (FD_PC !== 32'hFFFF_FFFC || FD_nop !== 1'b0)
      $display("FAIL wrap_fd got pc=%h nop=%b want fffffffc/0", FD_PC, FD_nop); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    repeat (3) @(negedge clk);
    D_flush = 1'b1; #1;
    total++; if (FD_PC !== 32'h4 || FD_nop !== 1'b0)
      $display("FAIL flush_pre got pc=%h nop=%b want 4/0", FD_PC, FD_nop); else passed++;
    @(negedge clk);
    D_flush = 1'b0; #1;
    total++; if (FD_nop !== 1'b1 || FD_instr !== NOP)
      $display("FAIL flush_fd got nop=%b instr=%h want 1/%h", FD_nop, FD_instr, NOP); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_predict();
    test_correct();
    test_drop();
    test_ready();
    test_wrap();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
